coin_credit_accumulator: RTL and testbench

// Upstream stage of vending_machine: turns coin-slot events into the running

---
 rtl/coin_credit_accumulator.sv | 170 +++++++++++++++++
 tb/tb_coin_credit_accumulator.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_credit_accumulator.sv
// Coin credit accumulator: turns coin-slot edges into a running credit that
// feeds the vending machine, clears it on a sale or refunds it on a cancel,
// enforces a credit ceiling and holds a short lockout after each transaction.
//
// Pulse outputs (O_COIN_ACK, O_REJECT, O_REFUND_VALID) are registered and are
// high for exactly the one cycle that follows the clock edge on which their
// event was decided; every output changes only on a rising clock edge or on
// reset. The debug output O_STATE carries the FSM state
// (0 = S_IDLE, 1 = S_ACCUM, 2 = S_LOCK).
module coin_credit_accumulator #(
  parameter int WIDTH       = 16,
  parameter int MAX_CREDIT  = 5000,
  parameter int LOCK_CYCLES = 4
) (
  input  logic             I_CLK,
  input  logic             I_RESET,
  input  logic             I_COIN_VALID,
  input  logic [2:0]       I_COIN_TYPE,
  input  logic             I_SUCCESS,
  input  logic             I_CANCEL,
  output logic [WIDTH-1:0] O_CHANGE,
  output logic [WIDTH-1:0] O_REFUND,
  output logic             O_REFUND_VALID,
  output logic             O_COIN_ACK,
  output logic             O_REJECT,
  output logic [1:0]       O_STATE
);

  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [WIDTH:0]   MAX_SUM   = (WIDTH + 1)'(MAX_CREDIT);
  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_LOCK  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             prev_valid_q;
  logic             armed_q;
  logic [WIDTH-1:0] change_q, change_d;
  logic [WIDTH-1:0] refund_q, refund_d;
  logic             refund_valid_q, refund_valid_d;
  logic             ack_q, ack_d;
  logic             reject_q, reject_d;

  logic             coin_evt;
  logic             code_ok;
  logic [WIDTH:0]   coin_val;
  logic [WIDTH:0]   sum;
  logic             coin_ok;
  logic             coin_rej;
  logic             do_sale;
  logic             do_cancel;
  logic             lock_done;

  // A coin is a rising edge of the slot level. armed_q stays low after reset
  // until the level has been seen low once, so a level held high across reset
  // release is not counted as a new coin.
  assign coin_evt = I_COIN_VALID & ~prev_valid_q & armed_q;

  // Coin code to value; codes 6 and 7 are invalid.
  always_comb begin
    coin_val = '0;
    code_ok  = 1'b1;
    case (I_COIN_TYPE)
      3'd0:    coin_val = (WIDTH + 1)'(1);
      3'd1:    coin_val = (WIDTH + 1)'(5);
      3'd2:    coin_val = (WIDTH + 1)'(10);
      3'd3:    coin_val = (WIDTH + 1)'(25);
      3'd4:    coin_val = (WIDTH + 1)'(100);
      3'd5:    coin_val = (WIDTH + 1)'(500);
      default: code_ok  = 1'b0;
    endcase
  end

  // One extra sum bit keeps the ceiling compare from wrapping.
  assign sum       = {1'b0, change_q} + coin_val;
  assign coin_ok   = coin_evt & code_ok & (sum <= MAX_SUM) & (state_q != S_LOCK)
                     & ~I_SUCCESS & ~I_CANCEL;
  assign coin_rej  = coin_evt & ~coin_ok;
  // Success wins over cancel when both arrive together.
  assign do_sale   = (state_q == S_ACCUM) & I_SUCCESS;
  assign do_cancel = (state_q == S_ACCUM) & I_CANCEL & ~I_SUCCESS;
  assign lock_done = (lock_cnt_q <= CNT_ONE);

  // State, lock counter, edge detector and datapath registers.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q        <= S_IDLE;
      lock_cnt_q     <= '0;
      prev_valid_q   <= 1'b0;
      armed_q        <= 1'b0;
      change_q       <= '0;
      refund_q       <= '0;
      refund_valid_q <= 1'b0;
      ack_q          <= 1'b0;
      reject_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      lock_cnt_q     <= lock_cnt_d;
      prev_valid_q   <= I_COIN_VALID;
      armed_q        <= armed_q | ~I_COIN_VALID;
      change_q       <= change_d;
      refund_q       <= refund_d;
      refund_valid_q <= refund_valid_d;
      ack_q          <= ack_d;
      reject_q       <= reject_d;
    end
  end

  // Next state; the lock counter loads on entry to S_LOCK so the lockout
  // covers exactly LOCK_CYCLES edges after the sale/cancel edge.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (coin_ok) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (do_sale || do_cancel) begin
          state_d    = S_LOCK;
          lock_cnt_d = LOCK_LOAD;
        end
      end
      S_LOCK: begin
        if (lock_done) begin
          state_d    = S_IDLE;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  // Credit, refund and pulse next values.
  always_comb begin
    change_d       = change_q;
    refund_d       = refund_q;
    refund_valid_d = 1'b0;
    ack_d          = coin_ok;
    reject_d       = coin_rej;
    if (do_sale) begin
      change_d = '0;
    end else if (do_cancel) begin
      refund_d       = change_q;
      refund_valid_d = 1'b1;
      change_d       = '0;
    end else if (coin_ok) begin
      change_d = sum[WIDTH-1:0];
    end
  end

  assign O_CHANGE       = change_q;
  assign O_REFUND       = refund_q;
  assign O_REFUND_VALID = refund_valid_q;
  assign O_COIN_ACK     = ack_q;
  assign O_REJECT       = reject_q;
  assign O_STATE        = state_q;

endmodule

// File: tb/tb_coin_credit_accumulator.sv
// Bench for coin_credit_accumulator: directed coin/sale/cancel/reset vectors,
// a transaction-level reference model, a per-cycle compare against it, and
// hand-computed literal expectations at the interesting points.
module tb_coin_credit_accumulator;

  localparam int WIDTH       = 16;
  localparam int MAX_CREDIT  = 5000;
  localparam int LOCK_CYCLES = 4;

  // ---------------- clock / reset ----------------
  logic             I_CLK = 1'b0;
  logic             I_RESET;
  logic             I_COIN_VALID;
  logic [2:0]       I_COIN_TYPE;
  logic             I_SUCCESS;
  logic             I_CANCEL;
  logic [WIDTH-1:0] O_CHANGE;
  logic [WIDTH-1:0] O_REFUND;
  logic             O_REFUND_VALID;
  logic             O_COIN_ACK;
  logic             O_REJECT;
  logic [1:0]       O_STATE;

  always #5 I_CLK = ~I_CLK;

  coin_credit_accumulator #(
    .WIDTH      (WIDTH),
    .MAX_CREDIT (MAX_CREDIT),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .I_CLK         (I_CLK),
    .I_RESET       (I_RESET),
    .I_COIN_VALID  (I_COIN_VALID),
    .I_COIN_TYPE   (I_COIN_TYPE),
    .I_SUCCESS     (I_SUCCESS),
    .I_CANCEL      (I_CANCEL),
    .O_CHANGE      (O_CHANGE),
    .O_REFUND      (O_REFUND),
    .O_REFUND_VALID(O_REFUND_VALID),
    .O_COIN_ACK    (O_COIN_ACK),
    .O_REJECT      (O_REJECT),
    .O_STATE       (O_STATE)
  );

  // ---------------- reference model ----------------
  // Credit is a plain integer; lockout is a deadline in edge numbers: after a
  // sale/cancel on edge n, edges n+1 .. n+LOCK_CYCLES are locked.
  int coin_tab [8] = '{1, 5, 10, 25, 100, 500, -1, -1};
  int m_k = 0;
  int m_lock_end = -100;
  int m_credit = 0;
  int m_refund = 0;
  int m_rv = 0, m_ack = 0, m_rej = 0, m_state = 0;
  int m_prev = 0, m_armed = 0;
  int m_val;
  bit m_in_lock, m_evt, m_ok;

  always @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      m_lock_end = -100;
      m_credit = 0; m_refund = 0;
      m_rv = 0; m_ack = 0; m_rej = 0; m_state = 0;
      m_prev = 0; m_armed = 0;
    end else begin
      m_k = m_k + 1;
      m_in_lock = (m_k <= m_lock_end);
      m_evt = I_COIN_VALID && (m_prev == 0) && (m_armed == 1);
      m_prev = I_COIN_VALID ? 1 : 0;
      if (!I_COIN_VALID) m_armed = 1;
      m_ack = 0; m_rej = 0; m_rv = 0;
      if (m_evt) begin
        m_val = coin_tab[I_COIN_TYPE];
        m_ok = (m_val > 0) && !m_in_lock && !I_SUCCESS && !I_CANCEL
               && (m_credit + m_val <= MAX_CREDIT);
        if (m_ok) begin
          m_credit = m_credit + m_val;
          m_ack = 1;
        end else begin
          m_rej = 1;
        end
      end
      if (!m_in_lock && m_credit > 0 && (I_SUCCESS || I_CANCEL)) begin
        if (!I_SUCCESS) begin
          m_refund = m_credit;
          m_rv = 1;
        end
        m_credit = 0;
        m_lock_end = m_k + LOCK_CYCLES;
      end
      m_state = (m_k < m_lock_end) ? 2 : ((m_credit > 0) ? 1 : 0);
    end
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    chk("cyc O_CHANGE",       32'(O_CHANGE),       32'(m_credit));
    chk("cyc O_REFUND",       32'(O_REFUND),       32'(m_refund));
    chk("cyc O_REFUND_VALID", 32'(O_REFUND_VALID), 32'(m_rv));
    chk("cyc O_COIN_ACK",     32'(O_COIN_ACK),     32'(m_ack));
    chk("cyc O_REJECT",       32'(O_REJECT),       32'(m_rej));
    chk("cyc O_STATE",        32'(O_STATE),        32'(m_state));
  endtask

  // ---------------- driver tasks ----------------
  // One clock edge, then compare on the following falling edge.
  task automatic tick();
    @(posedge I_CLK);
    @(negedge I_CLK);
    cmp_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Raise the slot for one edge; the caller may check the result, then the
  // next tick samples the slot low.
  task automatic coin(input logic [2:0] t);
    I_COIN_VALID = 1'b1;
    I_COIN_TYPE  = t;
    tick();
    I_COIN_VALID = 1'b0;
  endtask

  task automatic coin_gap(input logic [2:0] t);
    coin(t);
    tick();
  endtask

  task automatic pulse_success();
    I_SUCCESS = 1'b1;
    tick();
    I_SUCCESS = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    I_RESET = 1'b1;
    I_COIN_VALID = 1'b0; I_COIN_TYPE = 3'd0;
    I_SUCCESS = 1'b0; I_CANCEL = 1'b0;
    repeat (2) @(negedge I_CLK);

    // T1: reset state, then a single 100 coin
    chk("rst O_CHANGE", 32'(O_CHANGE), 32'd0);
    chk("rst O_REFUND", 32'(O_REFUND), 32'd0);
    chk("rst pulses", {29'd0, O_REFUND_VALID, O_COIN_ACK, O_REJECT}, 32'd0);
    chk("rst O_STATE", 32'(O_STATE), 32'd0);
    I_RESET = 1'b0;
    tick();
    coin(3'd4);
    chk("t1 change", 32'(O_CHANGE), 32'd100);
    chk("t1 ack", 32'(O_COIN_ACK), 32'd1);
    chk("t1 state", 32'(O_STATE), 32'd1);
    tick();
    chk("t1 ack no stretch", 32'(O_COIN_ACK), 32'd0);

    // T2: 100+100+25+25, sale, lockout boundaries
    coin_gap(3'd4); coin_gap(3'd3); coin_gap(3'd3);
    chk("t2 change 250", 32'(O_CHANGE), 32'd250);
    pulse_success();
    chk("t2 sale change", 32'(O_CHANGE), 32'd0);
    chk("t2 sale no refund", 32'(O_REFUND_VALID), 32'd0);
    chk("t2 sale state", 32'(O_STATE), 32'd2);
    tick();
    coin(3'd4);
    chk("t2 lock rej", 32'(O_REJECT), 32'd1);
    chk("t2 lock change", 32'(O_CHANGE), 32'd0);
    tick();
    coin(3'd4);
    chk("t2 last lock rej", 32'(O_REJECT), 32'd1);
    chk("t2 lock exit state", 32'(O_STATE), 32'd0);
    tick();
    coin_gap(3'd0);
    pulse_success();
    ticks(4);
    coin(3'd4);
    chk("t2 post-lock accept", 32'(O_CHANGE), 32'd100);
    chk("t2 post-lock ack", 32'(O_COIN_ACK), 32'd1);
    tick();

    // T3: invalid codes
    coin(3'd6);
    chk("t3 code6 rej", 32'(O_REJECT), 32'd1);
    chk("t3 code6 ack", 32'(O_COIN_ACK), 32'd0);
    chk("t3 code6 change", 32'(O_CHANGE), 32'd100);
    tick();
    coin(3'd7);
    chk("t3 code7 rej", 32'(O_REJECT), 32'd1);
    chk("t3 code7 change", 32'(O_CHANGE), 32'd100);
    tick();

    // T4: credit ceiling
    pulse_success();
    ticks(4);
    for (int i = 0; i < 9; i++) coin_gap(3'd5);
    for (int i = 0; i < 4; i++) coin_gap(3'd4);
    chk("t4 change 4900", 32'(O_CHANGE), 32'd4900);
    coin(3'd5);
    chk("t4 over rej", 32'(O_REJECT), 32'd1);
    chk("t4 over change", 32'(O_CHANGE), 32'd4900);
    tick();
    coin(3'd4);
    chk("t4 exact max", 32'(O_CHANGE), 32'd5000);
    tick();
    coin(3'd0);
    chk("t4 max+1 rej", 32'(O_REJECT), 32'd1);
    chk("t4 max+1 change", 32'(O_CHANGE), 32'd5000);
    tick();

    // T5: cancel/refund, success+cancel, cancel while idle, coin collision
    pulse_success();
    ticks(4);
    for (int i = 0; i < 3; i++) coin_gap(3'd4);
    I_CANCEL = 1'b1;
    tick();
    I_CANCEL = 1'b0;
    chk("t5 refund", 32'(O_REFUND), 32'd300);
    chk("t5 refund valid", 32'(O_REFUND_VALID), 32'd1);
    chk("t5 cancel change", 32'(O_CHANGE), 32'd0);
    tick();
    chk("t5 rv no stretch", 32'(O_REFUND_VALID), 32'd0);
    chk("t5 refund held", 32'(O_REFUND), 32'd300);
    ticks(3);
    for (int i = 0; i < 3; i++) coin_gap(3'd4);
    I_CANCEL = 1'b1; I_SUCCESS = 1'b1;
    tick();
    I_CANCEL = 1'b0; I_SUCCESS = 1'b0;
    chk("t5 both change", 32'(O_CHANGE), 32'd0);
    chk("t5 both no refund", 32'(O_REFUND_VALID), 32'd0);
    ticks(4);
    I_CANCEL = 1'b1;
    tick();
    I_CANCEL = 1'b0;
    chk("t5 idle cancel rv", 32'(O_REFUND_VALID), 32'd0);
    chk("t5 idle cancel state", 32'(O_STATE), 32'd0);
    coin_gap(3'd4);
    I_CANCEL = 1'b1;
    coin(3'd4);
    I_CANCEL = 1'b0;
    chk("t5 collision rej", 32'(O_REJECT), 32'd1);
    chk("t5 collision refund", 32'(O_REFUND), 32'd100);
    chk("t5 collision rv", 32'(O_REFUND_VALID), 32'd1);
    ticks(4);

    // T6: async reset mid-cycle with the slot held high across release
    coin_gap(3'd4); coin_gap(3'd3);
    chk("t6 change 125", 32'(O_CHANGE), 32'd125);
    I_COIN_VALID = 1'b1; I_COIN_TYPE = 3'd4;
    #2 I_RESET = 1'b1;
    #1;
    chk("t6 async change", 32'(O_CHANGE), 32'd0);
    chk("t6 async state", 32'(O_STATE), 32'd0);
    @(negedge I_CLK);
    I_RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6 held no coin", {31'd0, O_COIN_ACK}, 32'd0);
    end
    chk("t6 held change", 32'(O_CHANGE), 32'd0);
    I_COIN_VALID = 1'b0;
    tick();
    coin(3'd4);
    chk("t6 new coin", 32'(O_CHANGE), 32'd100);
    chk("t6 new coin ack", 32'(O_COIN_ACK), 32'd1);
    tick();

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
